// File: rtl/sub4_pkg.sv
// Shared constants and state type for the bit-serial 4-bit subtractor.
package sub4_pkg;

   localparam int W = 4;
   localparam logic [1:0] CNT_LAST = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/sub4bit_serial_fsub1.sv
// Single-bit full subtractor: the datapath cell used once per serial step.
module fsub1 (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   assign D    = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule

// File: rtl/sub4bit_serial.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, with start/busy/done handshake.
// Optional overflow output V is built only when OVERFLOW_DETECT_EN is defined.
module sub4bit_serial
   import sub4_pkg::*;
#(
   parameter int WIDTH = W
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] D,
   output logic             Bout
`ifdef OVERFLOW_DETECT_EN
   ,
   output logic             V
`endif
);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic [1:0]       cnt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res;
   logic             br;
   logic             d_bit;
   logic             br_next;
   logic             last_step;

   fsub1 u_cell (
      .A    (a_reg[0]),
      .B    (b_reg[0]),
      .Bin  (br),
      .D    (d_bit),
      .Bout (br_next)
   );

   assign last_step = (state == S_SHIFT) && (cnt == CNT_LAST);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Start is only honoured in IDLE or DONE, so a DONE cycle can chain straight into SHIFT.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            Busy = 1'b1;
            if (cnt == CNT_LAST) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            Done = 1'b1;
            if (Start) begin
               accept    = 1'b1;
               state_nxt = S_SHIFT;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // D and Bout are published only on the final step so they stay stable between operations.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt   <= 2'd0;
         a_reg <= '0;
         b_reg <= '0;
         res   <= '0;
         br    <= 1'b0;
         D     <= '0;
         Bout  <= 1'b0;
      end else if (accept) begin
         cnt   <= 2'd0;
         a_reg <= A;
         b_reg <= B;
         br    <= Bin;
      end else if (state == S_SHIFT) begin
         cnt   <= cnt + 2'd1;
         a_reg <= a_reg >> 1;
         b_reg <= b_reg >> 1;
         br    <= br_next;
         res   <= {d_bit, res[WIDTH-1:1]};
         if (last_step) begin
            D    <= {d_bit, res[WIDTH-1:1]};
            Bout <= br_next;
         end
      end
   end

`ifdef OVERFLOW_DETECT_EN
   // On the last step the operand LSBs are the sign bits and d_bit is the result sign.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         V <= 1'b0;
      end else if (last_step) begin
         V <= (a_reg[0] ^ b_reg[0]) & (d_bit ^ a_reg[0]);
      end
   end
`endif

endmodule

// File: tb/tb_sub4bit_serial.sv
// Self-checking bench for sub4bit_serial: vector table, corner sequences, exhaustive sweep.
module tb_sub4bit_serial;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bin;
      logic [3:0] d;
      logic       bout;
      logic       v;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic       Start = 1'b0;
   logic [3:0] A = 4'd0;
   logic [3:0] B = 4'd0;
   logic       Bin = 1'b0;
   logic       Busy;
   logic       Done;
   logic [3:0] D;
   logic       Bout;
   logic       V;

   int         checks = 0;
   int         failures = 0;
   logic [5:0] sb[$];
   logic [5:0] popped;
   vec_t       vecs[5];

`ifdef OVERFLOW_DETECT_EN
   localparam bit HAS_V = 1'b1;
`else
   localparam bit HAS_V = 1'b0;
   assign V = 1'b0;
`endif

   sub4bit_serial dut (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .Start (Start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .Busy  (Busy),
      .Done  (Done),
      .D     (D),
      .Bout  (Bout)
`ifdef OVERFLOW_DETECT_EN
      ,
      .V     (V)
`endif
   );

   always #5 CLK = ~CLK;

   // Expected {D, Bout, V} from plain modulo-16 arithmetic.
   function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic bin);
      logic [4:0] diff;
      logic [3:0] d;
      logic       bout;
      logic       v;
      diff = {1'b0, a} - {1'b0, b} - {4'b0, bin};
      d    = diff[3:0];
      bout = ({1'b0, a} < ({1'b0, b} + {4'b0, bin}));
      v    = (a[3] ^ b[3]) & (d[3] ^ a[3]) & HAS_V;
      return {d, bout, v};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (RSTn && Done) begin
         if (sb.size() == 0) begin
            checkOutput("done without pending op", 32'd1, 32'd0);
         end else begin
            popped = sb.pop_front();
            checkOutput("result {D,Bout,V}", {26'd0, D, Bout, V}, {26'd0, popped});
            checkOutput("busy clear during done", {31'd0, Busy}, 32'd0);
         end
      end
   end

   task automatic waitDone(output int busyCycles);
      int guard;
      busyCycles = 0;
      guard = 0;
      while (!Done && guard < 8) begin
         if (Busy) busyCycles++;
         @(posedge CLK);
         #1;
         guard++;
      end
      checkOutput("done reached", {31'd0, Done}, 32'd1);
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic bin,
                                input logic [5:0] exp);
      int busyCycles;
      A = a;
      B = b;
      Bin = bin;
      Start = 1'b1;
      sb.push_back(exp);
      @(posedge CLK);
      #1;
      Start = 1'b0;
      waitDone(busyCycles);
      checkOutput("busy cycle count", busyCycles, 32'd4);
      @(posedge CLK);
      #1;
      checkOutput("done single pulse", {31'd0, Done}, 32'd0);
      checkOutput("result held", {27'd0, D, Bout}, {27'd0, exp[5:1]});
   endtask

   initial begin
      int busyCycles;
      vecs[0] = '{a: 4'h7, b: 4'h3, bin: 1'b0, d: 4'h4, bout: 1'b0, v: 1'b0};
      vecs[1] = '{a: 4'h3, b: 4'h7, bin: 1'b0, d: 4'hC, bout: 1'b1, v: 1'b0};
      vecs[2] = '{a: 4'h0, b: 4'h0, bin: 1'b1, d: 4'hF, bout: 1'b1, v: 1'b0};
      vecs[3] = '{a: 4'hF, b: 4'hF, bin: 1'b0, d: 4'h0, bout: 1'b0, v: 1'b0};
      vecs[4] = '{a: 4'h7, b: 4'h8, bin: 1'b1, d: 4'hE, bout: 1'b1, v: 1'b1};

      #2;
      checkOutput("reset outputs", {26'd0, Busy, Done, D, Bout, V}, 32'd0);
      #10;
      RSTn = 1'b1;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin,
                       {vecs[i].d, vecs[i].bout, vecs[i].v & HAS_V});
      end

      // Start held through SHIFT with changing operands, then chained from DONE.
      A = 4'h2;
      B = 4'h1;
      Bin = 1'b0;
      Start = 1'b1;
      sb.push_back({4'h1, 1'b0, 1'b0});
      @(posedge CLK);
      #1;
      A = 4'hF;
      B = 4'h0;
      Bin = 1'b1;
      waitDone(busyCycles);
      checkOutput("first op busy count", busyCycles, 32'd4);
      A = 4'h8;
      B = 4'h1;
      Bin = 1'b0;
      sb.push_back({4'h7, 1'b0, HAS_V});
      @(posedge CLK);
      #1;
      Start = 1'b0;
      checkOutput("back-to-back no idle gap", {30'd0, Busy, Done}, 32'd2);
      waitDone(busyCycles);
      checkOutput("chained op busy count", busyCycles, 32'd4);
      @(posedge CLK);
      #1;
      checkOutput("chained done pulse", {31'd0, Done}, 32'd0);

      // Reset during the second SHIFT cycle discards the operation.
      A = 4'h9;
      B = 4'h4;
      Start = 1'b1;
      sb.push_back(model(4'h9, 4'h4, 1'b0));
      @(posedge CLK);
      #1;
      Start = 1'b0;
      @(posedge CLK);
      #1;
      RSTn = 1'b0;
      #1;
      checkOutput("mid-op reset busy", {31'd0, Busy}, 32'd0);
      checkOutput("mid-op reset done", {31'd0, Done}, 32'd0);
      checkOutput("mid-op reset D,Bout,V", {26'd0, D, Bout, V}, 32'd0);
      sb.delete();
      #2;
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
      applyStimulus(4'h5, 4'h2, 1'b0, {4'h3, 1'b0, 1'b0});

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               applyStimulus(4'(a), 4'(b), 1'(c), model(4'(a), 4'(b), 1'(c)));
            end
         end
      end

      checkOutput("scoreboard drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
